// File: rtl/counter_cmd_tx_if.sv
// counter_cmd_tx_if: command handshake between a command source and counter_cmd_tx.
interface counter_cmd_tx_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_cmd_tx.sv
// counter_cmd_tx: drives pin-level load/step sequences into an external up/down counter.
// Define COUNTER_CMD_TX_SHADOW_EN to track the expected receiver count on shadow_count.
module counter_cmd_tx #(
    parameter int HALF_PERIOD = 4,
    parameter int SETUP_CYC   = 4,
    parameter int HOLD_CYC    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    counter_cmd_tx_if.slave        cmd,
    output logic                   enable_o,
    output logic                   load_o,
    output logic                   clk_in_o,
    output logic                   up_down_o,
    output logic [7:0]             data_o,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             shadow_count
);
    typedef enum logic [2:0] {IDLE, SETUP, LOAD_HI, LOAD_LO, PULSE_HI, PULSE_LO, HOLD} state_t;

    localparam logic [7:0] HALF_M1  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] SETUP_M1 = 8'(SETUP_CYC - 1);
    localparam logic [7:0] HOLD_M1  = 8'(HOLD_CYC - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d, n_q, n_d, data_q, data_d;
    logic [1:0] op_q, op_d;
    logic       ud_q, ud_d, done_d;
    logic       ready_q, en_q, ld_q, ck_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        n_d     = n_q;
        data_d  = data_q;
        ud_d    = ud_q;
        unique case (state_q)
            IDLE: if (cmd.cmd_valid) begin
                state_d = SETUP;
                op_d    = cmd.cmd_op;
                n_d     = cmd.cmd_data;
                data_d  = cmd.cmd_op == 2'b00 ? cmd.cmd_data : data_q;
                ud_d    = cmd.cmd_op == 2'b01 ? 1'b1 : cmd.cmd_op == 2'b10 ? 1'b0 : ud_q;
            end
            SETUP: if (cnt_q == SETUP_M1)
                state_d = op_q == 2'b00 ? LOAD_HI :
                          (op_q != 2'b11 && n_q != 8'd0) ? PULSE_HI : HOLD;
            LOAD_HI:  if (cnt_q == HALF_M1) state_d = LOAD_LO;
            LOAD_LO:  if (cnt_q == HALF_M1) state_d = HOLD;
            PULSE_HI: if (cnt_q == HALF_M1) state_d = PULSE_LO;
            // the remaining count only moves at the end of a full pulse, so N=255 never wraps
            PULSE_LO: if (cnt_q == HALF_M1) begin
                n_d     = n_q - 8'd1;
                state_d = n_q == 8'd1 ? HOLD : PULSE_HI;
            end
            HOLD:     if (cnt_q == HOLD_M1) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        cnt_d  = (state_d != state_q || state_q == IDLE) ? 8'd0 : cnt_q + 8'd1;
        done_d = state_d == HOLD && cnt_d == HOLD_M1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            n_q     <= 8'd0;
            data_q  <= 8'd0;
            op_q    <= 2'b00;
            ud_q    <= 1'b0;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
            ld_q    <= 1'b0;
            ck_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            data_q  <= data_d;
            op_q    <= op_d;
            ud_q    <= ud_d;
            ready_q <= state_d == IDLE;
            en_q    <= state_d != IDLE;
            ld_q    <= state_d == LOAD_HI;
            ck_q    <= state_d == PULSE_HI;
            busy_q  <= state_d != IDLE;
            done_q  <= done_d;
        end
    end

`ifdef COUNTER_CMD_TX_SHADOW_EN
    logic [7:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (state_d == LOAD_HI && state_q != LOAD_HI)
            shadow_d = data_q;
        else if (state_d == PULSE_HI && state_q != PULSE_HI)
            shadow_d = op_q == 2'b01 ? shadow_q + 8'd1 : shadow_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= 8'd0;
        else        shadow_q <= shadow_d;
    end

    assign shadow_count = shadow_q;
`else
    assign shadow_count = 8'h00;
`endif

    assign cmd.cmd_ready = ready_q;
    assign enable_o      = en_q;
    assign load_o        = ld_q;
    assign clk_in_o      = ck_q;
    assign up_down_o     = ud_q;
    assign data_o        = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_counter_cmd_tx.sv
// tb_counter_cmd_tx: randomized scoreboard bench for counter_cmd_tx with a pin-level receiver model.
module tb_counter_cmd_tx;
    localparam int H  = 4;
    localparam int S  = 4;
    localparam int HC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_o, load_o, clk_in_o, up_down_o, busy, done;
    logic [7:0] data_o, shadow_count;

    always #5 clk = ~clk;

    counter_cmd_tx_if cif();

    counter_cmd_tx #(.HALF_PERIOD(H), .SETUP_CYC(S), .HOLD_CYC(HC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cif),
        .enable_o(enable_o), .load_o(load_o), .clk_in_o(clk_in_o), .up_down_o(up_down_o),
        .data_o(data_o), .busy(busy), .done(done), .shadow_count(shadow_count)
    );

    typedef struct {
        int         t_acc;
        int         lat;
        int         loads;
        int         pulses;
        logic [7:0] data;
        logic       ud;
        logic [7:0] recv;
        logic       recv_known;
        logic [7:0] shadow;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0, n_bad = 0, cyc = 0, last_done = -1, last_acc = -1;
    logic [7:0] m_data = 8'd0, m_recv = 8'd0, m_shadow = 8'd0;
    logic       m_ud = 1'b0, m_known = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a command does to the receiver, from the command alone.
    task automatic model(input logic [1:0] op, input logic [7:0] d, input int t);
        exp_t e;
        e.t_acc  = t;
        e.loads  = 0;
        e.pulses = 0;
        if (op == 2'b00) begin
            m_data   = d;
            m_recv   = d;
            m_shadow = d;
            m_known  = 1'b1;
            e.loads  = 1;
            e.lat    = S + 2 * H + HC;
        end else if (op == 2'b11 || d == 8'd0) begin
            if (op != 2'b11) m_ud = (op == 2'b01);
            e.lat = S + HC;
        end else begin
            m_ud     = (op == 2'b01);
            m_recv   = m_ud ? 8'(m_recv + d) : 8'(m_recv - d);
            m_shadow = m_ud ? 8'(m_shadow + d) : 8'(m_shadow - d);
            e.pulses = int'(d);
            e.lat    = S + 2 * H * int'(d) + HC;
        end
        e.data       = m_data;
        e.ud         = m_ud;
        e.recv       = m_recv;
        e.recv_known = m_known;
`ifdef COUNTER_CMD_TX_SHADOW_EN
        e.shadow = m_shadow;
`else
        e.shadow = 8'h00;
`endif
        last_acc = t;
        q.push_back(e);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        for (int i = 0; i < 5000; i++) begin
            if (cif.cmd_ready) begin
                model(op, d, cyc);
                @(posedge clk);
                #1 cif.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 0, 1);
        cif.cmd_valid = 1'b0;
    endtask

    // Monitor: pin-level receiver plus per-transaction activity, checked at each done.
    initial begin
        int         en_c, ld_c, ld_r, ck_c, ck_r;
        logic       ov, pl, pc, chk_rdy;
        logic [7:0] recv;
        exp_t       e;
        en_c = 0; ld_c = 0; ld_r = 0; ck_c = 0; ck_r = 0;
        ov = 0; pl = 0; pc = 0; chk_rdy = 0; recv = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_c = 0; ld_c = 0; ld_r = 0; ck_c = 0; ck_r = 0;
                ov = 0; pl = 0; pc = 0; chk_rdy = 0;
            end else begin
                if (chk_rdy) begin
                    chk("ready_after_done", int'(cif.cmd_ready), 1);
                    chk("busy_after_done", int'(busy), 0);
                    chk("enable_after_done", int'(enable_o), 0);
                    chk_rdy = 0;
                end
                en_c += int'(enable_o);
                ld_c += int'(load_o);
                ck_c += int'(clk_in_o);
                if (load_o && !pl) begin ld_r++; recv = data_o; end
                if (clk_in_o && !pc) begin ck_r++; recv = up_down_o ? 8'(recv + 1) : 8'(recv - 1); end
                ov = ov | (load_o & clk_in_o);
                pl = load_o;
                pc = clk_in_o;
                if (done) begin
                    last_done = cyc;
                    if (q.size() == 0) chk("unexpected_done", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("done_latency", cyc - e.t_acc, e.lat);
                        chk("enable_cycles", en_c, e.lat);
                        chk("load_rises", ld_r, e.loads);
                        chk("load_high_cycles", ld_c, e.loads * H);
                        chk("clk_in_rises", ck_r, e.pulses);
                        chk("clk_in_high_cycles", ck_c, e.pulses * H);
                        chk("data_o", int'(data_o), int'(e.data));
                        chk("up_down_o", int'(up_down_o), int'(e.ud));
                        if (e.recv_known) chk("receiver_count", int'(recv), int'(e.recv));
                        chk("shadow_count", int'(shadow_count), int'(e.shadow));
                        chk("load_clk_overlap", int'(ov), 0);
                        chk("busy_at_done", int'(busy), 1);
                    end
                    en_c = 0; ld_c = 0; ld_r = 0; ck_c = 0; ck_r = 0; ov = 0;
                    chk_rdy = 1;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_enable"}, int'(enable_o), 0);
        chk({tag, "_load"}, int'(load_o), 0);
        chk({tag, "_clk_in"}, int'(clk_in_o), 0);
        chk({tag, "_up_down"}, int'(up_down_o), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_data"}, int'(data_o), 0);
        chk({tag, "_shadow"}, int'(shadow_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [7:0] d;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_data  = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("reset");
        chk("reset_ready", int'(cif.cmd_ready), 1);

        send(2'b00, 8'hA5);
        send(2'b00, 8'hFE);
        send(2'b01, 8'd3);
        send(2'b10, 8'd0);
        send(2'b11, 8'h5A);

        send(2'b01, 8'd2);
        send(2'b10, 8'd1);
        chk("b2b_accept_cycle", last_acc, last_done + 1);

        send(2'b01, 8'd255);

        repeat (30) begin
            op = 2'($urandom_range(0, 3));
            d  = op == 2'b00 ? 8'($urandom) : 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 5)) @(negedge clk);
            send(op, d);
        end

        send(2'b01, 8'd10);
        for (int i = 0; i < 2000 && !clk_in_o; i++) @(negedge clk);
        chk("pulse_before_reset", int'(clk_in_o), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        q.delete();
        m_data = 8'd0; m_ud = 1'b0; m_shadow = 8'd0; m_known = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", int'(cif.cmd_ready), 1);
        send(2'b00, 8'h10);

        for (int i = 0; i < 5000 && q.size() != 0; i++) @(negedge clk);
        chk("drain_pending", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
